// File: rtl/reg_pkg.sv
// Shared register-file constants and the write-back request record.
package reg_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int REG_COUNT  = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter with its own rotating priority pointer.
// Search starts at the pointer and wraps; the pointer moves just past the
// winner whenever a grant is issued.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         EN,
   input  logic [N-1:0] REQ,
   output logic [N-1:0] GRANT
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_next;
   logic [N-1:0]  req_hi;
   logic [N-1:0]  pick;

   // Prefer requesters at or above the pointer, otherwise fall back to the lowest index.
   always_comb begin
      req_hi = '0;
      pick   = '0;
      for (int i = 0; i < N; i++) begin
         req_hi[i] = REQ[i] && (i >= int'(ptr_q));
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (req_hi != '0) begin
            if (req_hi[i]) pick = N'(1) << i;
         end else begin
            if (REQ[i]) pick = N'(1) << i;
         end
      end
      GRANT = EN ? pick : '0;
   end

   // Index one past the winner, wrapping at N.
   always_comb begin
      ptr_next = ptr_q;
      for (int i = 0; i < N; i++) begin
         if (GRANT[i]) ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
      end
   end

   // Pointer register; only a grant moves it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) ptr_q <= '0;
      else       ptr_q <= ptr_next;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: round-robin among NUM_REQ write-back
// requesters, winner registered onto the write port one cycle later.
// Address 0 is accepted but never written.
// Optional REG_WB_SCOREBOARD_EN adds a pending-write scoreboard
// (RSV_VALID/RSV_ADDR in, PENDING out).
module reg_wb_arbiter
   import reg_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      STALL,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
   output logic [NUM_REQ-1:0]        REQ_READY,
`ifdef REG_WB_SCOREBOARD_EN
   input  logic                      RSV_VALID,
   input  logic [ADDR_W-1:0]         RSV_ADDR,
   output logic [REG_COUNT-1:0]      PENDING,
`endif
   output logic                      WRITE_ENABLE,
   output logic [ADDR_W-1:0]         WRITE_ADDRESS,
   output logic [DATA_W-1:0]         WRITE_DATA
);

   logic              grant_en;
   logic              xfer;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Reset also blocks grants so nothing is accepted while it is held.
   assign grant_en = ~STALL & ~RESET;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (grant_en),
      .REQ   (REQ_VALID),
      .GRANT (REQ_READY)
   );

   assign xfer = |REQ_READY;

   // Select the winner's address and data from the packed request buses.
   always_comb begin
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (REQ_READY[i]) begin
            win_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
            win_data = REQ_DATA[i*DATA_W +: DATA_W];
         end
      end
   end

   // Write-port register; enable is a one-cycle pulse, address/data hold otherwise.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         WRITE_ENABLE  <= 1'b0;
         WRITE_ADDRESS <= '0;
         WRITE_DATA    <= '0;
      end else if (xfer) begin
         WRITE_ENABLE  <= (win_addr != '0);
         WRITE_ADDRESS <= win_addr;
         WRITE_DATA    <= win_data;
      end else begin
         WRITE_ENABLE  <= 1'b0;
      end
   end

`ifdef REG_WB_SCOREBOARD_EN
   logic [REG_COUNT-1:0] set_mask;
   logic [REG_COUNT-1:0] clr_mask;

   // Decode reservation and granted write into per-register set/clear masks.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int a = 1; a < REG_COUNT; a++) begin
         set_mask[a] = RSV_VALID && (RSV_ADDR == ADDR_W'(a));
         clr_mask[a] = xfer && (win_addr == ADDR_W'(a));
      end
   end

   // Pending bits; a same-edge set overrides the clear, bit 0 stays low.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) PENDING <= '0;
      else       PENDING <= (PENDING & ~clr_mask) | set_mask;
   end
`endif

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the register file's single write port among NUM_REQ write-back requesters, such as the ALU, load unit and CSR/mult unit.
- Arbitration is round-robin over a valid/ready handshake per requester.
- The winner's address and data are registered and driven onto the register file's WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA inputs one cycle later.
- Sits between the execute/memory stages and the register file.

Parameters:
NUM_REQ, 2, number of write-back requesters (legal 2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  asynchronous, active-high reset
STALL  input  1  when 1, no grants are issued this cycle
REQ_VALID  input  NUM_REQ  requester i has a write pending
REQ_ADDR  input  NUM_REQ*ADDR_W  destination of requester i, slice [i*ADDR_W +: ADDR_W]
REQ_DATA  input  NUM_REQ*DATA_W  data of requester i, slice [i*DATA_W +: DATA_W]
REQ_READY  output  NUM_REQ  one-hot grant; requester i's write is accepted this cycle
WRITE_ENABLE  output  1  to register file write enable (registered)
WRITE_ADDRESS  output  ADDR_W  to register file write address (registered)
WRITE_DATA  output  DATA_W  to register file write data (registered)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0.
  - Round-robin pointer PTR=0.
  - REQ_READY=0 while RESET is high.
- Grant (combinational from REQ_VALID, PTR, STALL):
  - If STALL=0, grant the first valid requester searching PTR, PTR+1, ... wrapping modulo NUM_REQ.
  - REQ_READY is one-hot or zero. It is never asserted for a requester with REQ_VALID=0.
- Transfer: REQ_VALID[i] & REQ_READY[i] at a posedge.
- Requester rules:
  - Hold REQ_ADDR/REQ_DATA stable while REQ_VALID=1 and not yet granted.
  - Do not deassert REQ_VALID before the grant.
- PTR update: on each transfer, PTR <= (granted index + 1) mod NUM_REQ. Unchanged when there is no transfer or STALL=1.
- Output stage: on a transfer, WRITE_ADDRESS/WRITE_DATA <= granted address/data on the same edge.
  - WRITE_ENABLE <= 1 if the address is nonzero.
  - Address 0: the request is accepted (REQ_READY=1, PTR advances) but WRITE_ENABLE <= 0. Register 0 is never written.
  - No transfer: WRITE_ENABLE <= 0; WRITE_ADDRESS/WRITE_DATA hold their previous values.
- Latency: grant at edge N, register file write at edge N+1.
- Throughput: one write per cycle. The output stage never back-pressures.
- Same-address writes from different requesters are serialised in grant order. The later grant wins in the register file.
- STALL=1: REQ_READY=0; WRITE_ENABLE <= 0 at the next edge. A write already registered completes normally.
- RESET mid-operation: pending requests are not accepted. An output write registered before reset is discarded (WRITE_ENABLE forced to 0).

Optional Feature:
- Macro: REG_WB_SCOREBOARD_EN.
- Defined:
  - Added ports RSV_VALID input 1, RSV_ADDR input ADDR_W, PENDING output 32.
  - PENDING[a] is set at the edge where RSV_VALID=1 and RSV_ADDR=a (a!=0).
  - PENDING[a] is cleared at the edge where a transfer to address a is granted.
  - Set and clear of the same address on the same edge: set wins.
  - PENDING[0] is always 0. Reset clears all bits.
- Undefined: none of these ports or this state exist.

Decomposition:
- Shared package reg_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32.
  - Typedef wb_req_t {addr, data}.
- One sub-module, rr_arbiter: a parameterised round-robin one-hot grant with pointer register, reusable elsewhere.
- Output register and scoreboard stay in the top level.

Test Plan:
- Reset with REQ_VALID=2'b11 asserted -> REQ_READY=0, WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0; after release first grant goes to requester 0.
- Requester 0 only, addr 5, data 0xDEADBEEF -> REQ_READY=01 at edge N; at edge N+1 WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF; next cycle WRITE_ENABLE=0.
- Both requesters continuously valid (addr 3/data 0x11, addr 4/data 0x22) for 4 cycles -> grants 01,10,01,10; writes 3,4,3,4 one cycle behind.
- Requester 1 valid, addr 0, data 0xFFFFFFFF -> REQ_READY=10, PTR becomes 0, WRITE_ENABLE stays 0.
- STALL=1 for 3 cycles with both valid -> no REQ_READY, WRITE_ENABLE=0; after release grant order resumes from the unchanged PTR.
- (REG_WB_SCOREBOARD_EN) RSV addr 7 -> PENDING[7]=1 next cycle; grant to addr 7 with RSV addr 7 on the same edge -> PENDING[7] stays 1; grant alone -> PENDING[7]=0.
